// File: rtl/pmem_scheduler_pkg.sv
// Shared LC-3b types used by the pmem scheduler.
// Holds the word type and the scheduler state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_I,
    SCHED_D
  } lc3b_sched_state;

endpackage

// File: rtl/pmem_scheduler_sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Used for the optional scheduler performance counters.
module sat_counter
  import lc3b_types::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pmem_scheduler.sv
// Arbitrates the pmem port between icache and dcache, dcache first.
// Perf counters are built only when PMEM_SCHED_PERF_EN is defined.
module pmem_scheduler
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_pmem_read,
  input  lc3b_word         icache_pmem_address,
  input  logic             dcache_pmem_read,
  input  logic             dcache_pmem_write,
  input  lc3b_word         dcache_pmem_address,
  input  logic             pmem_resp,
  output logic             icache_pmem_resp,
  output logic             dcache_pmem_resp,
  output lc3b_word         pmem_address,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             ld_regs,
  output logic [CNT_W-1:0] perf_igrant,
  output logic [CNT_W-1:0] perf_dgrant,
  output logic [CNT_W-1:0] perf_conflict
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  lc3b_sched_state state;
  logic [SW-1:0]   starve_cnt;

  logic i_req, d_req;
  logic grant_i, grant_d, conflict;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // Icache wins only when alone or after the starvation bound is hit.
  assign grant_i = (state == SCHED_IDLE) && i_req &&
                   (!d_req || starve_cnt == LIM);
  assign grant_d = (state == SCHED_IDLE) && d_req && !grant_i;
  assign conflict = (grant_i | grant_d) & i_req & d_req;

  assign ld_regs = !(icache_pmem_read | dcache_pmem_read |
                     dcache_pmem_write);

  assign icache_pmem_resp = (state == SCHED_I) & pmem_resp;
  assign dcache_pmem_resp = (state == SCHED_D) & pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SCHED_IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      starve_cnt   <= '0;
    end else begin
      unique case (state)
        SCHED_IDLE: begin
          unique case (1'b1)
            grant_i: begin
              state        <= SCHED_I;
              pmem_address <= icache_pmem_address;
              pmem_read    <= 1'b1;
              pmem_write   <= 1'b0;
              starve_cnt   <= '0;
            end
            grant_d: begin
              state        <= SCHED_D;
              pmem_address <= dcache_pmem_address;
              pmem_write   <= dcache_pmem_write;
              pmem_read    <= !dcache_pmem_write;
              if (i_req && starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
            end
            default: ;
          endcase
        end
        SCHED_I, SCHED_D: begin
          if (pmem_resp) begin
            state      <= SCHED_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

`ifdef PMEM_SCHED_PERF_EN
  sat_counter #(.width(CNT_W)) u_igrant (
    .clk(clk), .rst(rst), .inc(grant_i), .count(perf_igrant)
  );
  sat_counter #(.width(CNT_W)) u_dgrant (
    .clk(clk), .rst(rst), .inc(grant_d), .count(perf_dgrant)
  );
  sat_counter #(.width(CNT_W)) u_conflict (
    .clk(clk), .rst(rst), .inc(conflict), .count(perf_conflict)
  );
`else
  assign perf_igrant   = '0;
  assign perf_dgrant   = '0;
  assign perf_conflict = '0;
`endif

endmodule
